// File: rtl/uart_command_serializer.sv
// uart_command_serializer
// Streams a captured command buffer (byte 0 first) to a UART TX core over a
// valid/ready link and appends the side-specific terminator: 0x0D on the BLE
// side, 0xBE 0xEF otherwise. A transfer ends in DONE with a one-cycle done
// pulse whether it completed, was aborted, or timed out on a stalled sink.
//
// Handshake: a byte moves on every rising edge where tx_valid and tx_ready
// are both high. Once tx_valid is raised, tx_data and tx_valid stay fixed
// until that handshake happens, or until abort/timeout withdraws the offer.
module uart_command_serializer #(
   parameter int TIMEOUT = 2000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1023:0] input_data,
   input  logic [7:0]    input_data_size,
   input  logic          start,
   input  logic          ble_side,
   input  logic          abort,
   input  logic          tx_ready,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   output logic [7:0]    tx_count,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEND  = 3'd1,
      TERM1 = 3'd2,
      TERM2 = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT - 1);

   state_t          state_q;
   logic [1023:0]   buf_q;     // remaining payload, next byte in bits [7:0]
   logic [7:0]      size_q;
   logic [7:0]      idx_q;     // index of the byte currently offered
   logic            ble_q;
   logic [TW-1:0]   timer_q;   // consecutive stalled cycles

   logic hs;
   logic stall;

   assign hs        = tx_valid && tx_ready;
   assign stall     = tx_valid && !tx_ready;
   assign state_dbg = state_q;

   // Transfer FSM with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         buf_q    <= '0;
         size_q   <= 8'd0;
         idx_q    <= 8'd0;
         ble_q    <= 1'b0;
         timer_q  <= '0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         tx_count <= 8'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               timer_q <= '0;
               if (start) begin
                  buf_q    <= input_data;
                  size_q   <= input_data_size;
                  ble_q    <= ble_side;
                  idx_q    <= 8'd0;
                  tx_count <= 8'd0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  if (input_data_size == 8'd0 || input_data_size > 8'd128) begin
                     // Nothing is offered for an out-of-range size.
                     error   <= 1'b1;
                     done    <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     tx_data  <= input_data[7:0];
                     tx_valid <= 1'b1;
                     state_q  <= SEND;
                  end
               end
            end

            SEND, TERM1, TERM2: begin
               if (abort) begin
                  // Abort wins over a same-cycle handshake; that byte is not counted.
                  tx_valid <= 1'b0;
                  error    <= 1'b1;
                  done     <= 1'b1;
                  timer_q  <= '0;
                  state_q  <= DONE;
               end else if (hs) begin
                  timer_q  <= '0;
                  tx_count <= tx_count + 8'd1;
                  if (state_q == SEND) begin
                     if (idx_q == size_q - 8'd1) begin
                        tx_data <= ble_q ? 8'h0D : 8'hBE;
                        state_q <= TERM1;
                     end else begin
                        idx_q   <= idx_q + 8'd1;
                        buf_q   <= {8'h00, buf_q[1023:8]};
                        tx_data <= buf_q[15:8];
                     end
                  end else if (state_q == TERM1 && !ble_q) begin
                     tx_data <= 8'hEF;
                     state_q <= TERM2;
                  end else begin
                     tx_valid <= 1'b0;
                     done     <= 1'b1;
                     state_q  <= DONE;
                  end
               end else if (stall) begin
                  if (timer_q == STALL_LAST) begin
                     // Sink has been stuck for TIMEOUT cycles: give up.
                     tx_valid <= 1'b0;
                     error    <= 1'b1;
                     done     <= 1'b1;
                     timer_q  <= '0;
                     state_q  <= DONE;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
            end

            DONE: begin
               busy    <= 1'b0;
               timer_q <= '0;
               state_q <= IDLE;
            end

            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_command_serializer.sv
// Directed bench for uart_command_serializer. Expected bytes are queued when
// a transfer is started and popped at each observed handshake.
module tb_uart_command_serializer;

   logic          clk;
   logic          reset;
   logic [1023:0] input_data;
   logic [7:0]    input_data_size;
   logic          start;
   logic          ble_side;
   logic          abort;
   logic          tx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic [7:0]    tx_count;
   logic          busy;
   logic          done;
   logic          error;
   logic [2:0]    state_dbg;

   uart_command_serializer #(.TIMEOUT(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .input_data      (input_data),
      .input_data_size (input_data_size),
      .start           (start),
      .ble_side        (ble_side),
      .abort           (abort),
      .tx_ready        (tx_ready),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_count        (tx_count),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .state_dbg       (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard and bookkeeping
   logic [7:0]    exp_q[$];
   int            tests = 0;
   int            fails = 0;
   int            rel;
   int            done_cnt;
   int            done_at;
   int            hs_cnt;
   int            last_valid;
   logic [7:0]    done_count;
   logic          done_err;
   logic          stall_prev;
   logic [7:0]    held_data;
   logic [1023:0] pay;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at negedge, then step past the rising edge.
   task automatic tick();
      logic [7:0] e;
      @(negedge clk);
      if (!reset) begin
         if (stall_prev && tx_valid)
            check("stall_hold", {24'd0, tx_data}, {24'd0, held_data});
         if (tx_valid && tx_ready && !abort) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", {24'd0, tx_data}, {24'd0, e});
            end
         end
         stall_prev = tx_valid && !tx_ready && !abort;
         held_data  = tx_data;
         if (tx_valid) last_valid = rel;
         if (done) begin
            done_cnt++;
            done_at    = rel;
            done_count = tx_count;
            done_err   = error;
            check("busy_in_done", {31'd0, busy}, 32'd1);
         end
      end
      @(posedge clk);
      #1;
      rel++;
   endtask

   task automatic begin_xfer(input logic [7:0] size, input logic ble);
      input_data      = pay;
      input_data_size = size;
      ble_side        = ble;
      if (size != 8'd0 && size <= 8'd128) begin
         for (int i = 0; i < int'(size); i++) exp_q.push_back(pay[8*i +: 8]);
         if (ble) exp_q.push_back(8'h0D);
         else begin
            exp_q.push_back(8'hBE);
            exp_q.push_back(8'hEF);
         end
      end
      rel        = 0;
      done_cnt   = 0;
      done_at    = -1;
      hs_cnt     = 0;
      last_valid = -1;
      stall_prev = 1'b0;
      start      = 1'b1;
      tick();
      start           = 1'b0;
      // Captured copy must be used, not the live inputs.
      input_data      = {32{$urandom}};
      input_data_size = 8'($urandom_range(0, 255));
      ble_side        = ~ble;
   endtask

   task automatic wait_done(input int max, input bit toggle);
      while (done_cnt == 0 && rel <= max) begin
         if (toggle) tx_ready = ~tx_ready;
         tick();
      end
      check("done_seen", done_cnt, 32'd1);
      tick();
      check("done_one_cycle", done_cnt, 32'd1);
      check("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic run(input logic [7:0] size, input logic ble, input bit toggle,
                      input int exp_at, input int exp_cnt, input logic exp_err, string tag);
      begin_xfer(size, ble);
      wait_done(400, toggle);
      check({tag, "_done_at"}, done_at, exp_at);
      check({tag, "_count"}, {24'd0, done_count}, exp_cnt);
      check({tag, "_error"}, {31'd0, done_err}, {31'd0, exp_err});
      check({tag, "_queue_left"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
      ble_side = 1'b0; input_data = '0; input_data_size = 8'd0;
      pay = '0; stall_prev = 1'b0; rel = 0; done_cnt = 0; hs_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_data", {24'd0, tx_data}, 32'h00);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_count", {24'd0, tx_count}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      reset = 1'b0;
      tick();

      // BLE, 41 42 43 + 0D, ready held high: done at cycle 5.
      pay = '0;
      pay[23:0] = 24'h434241;
      run(8'd3, 1'b1, 1'b0, 5, 4, 1'b0, "ble3");

      // Non-BLE, 10 20 + BE EF, ready toggling from 0: handshakes on even cycles.
      pay = '0;
      pay[15:0] = 16'h2010;
      tx_ready = 1'b1;
      run(8'd2, 1'b0, 1'b1, 9, 4, 1'b0, "tog2");
      check("tog2_handshakes", hs_cnt, 32'd4);
      tx_ready = 1'b1;

      // 128 incrementing bytes, BLE: 129 handshakes, done at cycle 130.
      for (int i = 0; i < 128; i++) pay[8*i +: 8] = 8'(i);
      run(8'd128, 1'b1, 1'b0, 130, 129, 1'b0, "full128");
      check("full128_handshakes", hs_cnt, 32'd129);

      // Invalid sizes: done at cycle 1, nothing offered, error held afterwards.
      run(8'd0, 1'b0, 1'b0, 1, 0, 1'b1, "size0");
      check("size0_no_valid", last_valid, -1);
      check("size0_error_held", {31'd0, error}, 32'd1);
      run(8'd200, 1'b1, 1'b0, 1, 0, 1'b1, "size200");
      check("size200_no_valid", last_valid, -1);

      // Timeout: first byte accepted, then 8 stalled cycles (2..9), done at 10.
      for (int i = 0; i < 128; i++) pay[8*i +: 8] = 8'($urandom_range(0, 255));
      tx_ready = 1'b1;
      begin_xfer(8'd3, 1'b1);
      tick();
      tx_ready = 1'b0;
      wait_done(40, 1'b0);
      check("tmo_done_at", done_at, 32'd10);
      check("tmo_last_valid", last_valid, 32'd9);
      check("tmo_count", {24'd0, done_count}, 32'd1);
      check("tmo_error", {31'd0, done_err}, 32'd1);
      exp_q.delete();
      tx_ready = 1'b1;

      // Abort while byte 2 of 5 is offered: that byte is not counted.
      begin_xfer(8'd5, 1'b0);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done(40, 1'b0);
      check("abort_done_at", done_at, 32'd4);
      check("abort_count", {24'd0, done_count}, 32'd2);
      check("abort_error", {31'd0, done_err}, 32'd1);
      check("abort_handshakes", hs_cnt, 32'd2);
      exp_q.delete();
      run(8'd1, 1'b1, 1'b0, 3, 2, 1'b0, "after_abort");

      // Reset mid-transfer: outputs cleared at once, no done pulse.
      begin_xfer(8'd5, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_tx_data", {24'd0, tx_data}, 32'h00);
      check("mid_rst_tx_count", {24'd0, tx_count}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_error", {31'd0, error}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("mid_rst_no_done", done_cnt, 32'd0);
      check("mid_rst_done_low", {31'd0, done}, 32'd0);
      exp_q.delete();
      run(8'd2, 1'b0, 1'b0, 5, 4, 1'b0, "after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
